// File: rtl/score_pkg.sv
// Shared types and default point values for the BCD score counter.
package score_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] pend_t;

  typedef enum logic [1:0] {
    IDLE,
    ADD_ONES,
    ADD_TENS,
    ADD_HUNDREDS
  } score_state_t;

  // Default BCD point values, [11:8]=hundreds, [7:4]=tens, [3:0]=ones
  localparam logic [11:0] PELLET_PTS_DEF = 12'h010;
  localparam logic [11:0] POWER_PTS_DEF  = 12'h050;
  localparam logic [11:0] FRUIT_PTS_DEF  = 12'h100;
  localparam logic [11:0] GHOST_PTS_DEF  = 12'h200;

  // Bit positions of each event type in the packed event/select vectors
  localparam int EV_PELLET = 0;
  localparam int EV_POWER  = 1;
  localparam int EV_FRUIT  = 2;
  localparam int EV_GHOST  = 3;

endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder with carry, shared by every digit step of the score add.
module bcd_digit_adder
  import score_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic carryIn,
  output bcd_t digit,
  output logic carryOut
);

  logic [4:0] sum;
  logic [4:0] sumMinusTen;

  // Binary sum of the two digits, folded back into 0..9 with a decimal carry
  always_comb begin
    sum         = {1'b0, a} + {1'b0, b} + {4'b0000, carryIn};
    sumMinusTen = sum - 5'd10;
    if (sum > 5'd9) begin
      digit    = sumMinusTen[3:0];
      carryOut = 1'b1;
    end else begin
      digit    = sum[3:0];
      carryOut = 1'b0;
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Game score accumulator: queues game events, adds their points one BCD
// digit per cycle, and publishes the score to the display only at frame start.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter logic [11:0] PELLET_PTS = PELLET_PTS_DEF,
  parameter logic [11:0] POWER_PTS  = POWER_PTS_DEF,
  parameter logic [11:0] FRUIT_PTS  = FRUIT_PTS_DEF,
  parameter logic [11:0] GHOST_PTS  = GHOST_PTS_DEF
)
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       newGame,
  input  logic       pelletEaten,
  input  logic       powerEaten,
  input  logic       fruitEaten,
  input  logic       ghostEaten,
  output logic [3:0] onesDigit,
  output logic [3:0] tensDigit,
  output logic [3:0] hundredsDigit,
  output logic       busy,
  output logic       scoreSaturated
);

  score_state_t state;
  score_state_t nextState;

  pend_t       pend [4];
  logic [3:0]  events;
  logic [3:0]  select;
  logic [11:0] selAddend;
  logic [11:0] acc;
  logic [11:0] addend;
  logic        carry;

  bcd_t        accDigit;
  bcd_t        addDigit;
  bcd_t        sumDigit;
  logic        sumCarry;

  assign events = {ghostEaten, fruitEaten, powerEaten, pelletEaten};
  assign busy   = (state != IDLE);

  // Pick the highest-priority pending event while idle (ghost > fruit > power > pellet)
  always_comb begin
    select    = 4'b0000;
    selAddend = 12'h000;
    if (state == IDLE && !newGame) begin
      if (pend[EV_GHOST] != 2'd0) begin
        select[EV_GHOST] = 1'b1;
        selAddend        = GHOST_PTS;
      end else if (pend[EV_FRUIT] != 2'd0) begin
        select[EV_FRUIT] = 1'b1;
        selAddend        = FRUIT_PTS;
      end else if (pend[EV_POWER] != 2'd0) begin
        select[EV_POWER] = 1'b1;
        selAddend        = POWER_PTS;
      end else if (pend[EV_PELLET] != 2'd0) begin
        select[EV_PELLET] = 1'b1;
        selAddend         = PELLET_PTS;
      end
    end
  end

  // Route the digit pair for the current add step into the shared adder
  always_comb begin
    accDigit = acc[3:0];
    addDigit = addend[3:0];
    case (state)
      ADD_TENS: begin
        accDigit = acc[7:4];
        addDigit = addend[7:4];
      end
      ADD_HUNDREDS: begin
        accDigit = acc[11:8];
        addDigit = addend[11:8];
      end
      default: ;
    endcase
  end

  bcd_digit_adder digitAdder (
    .a        (accDigit),
    .b        (addDigit),
    .carryIn  (carry),
    .digit    (sumDigit),
    .carryOut (sumCarry)
  );

  // Next-state logic: ones -> tens -> hundreds, newGame always returns to idle
  always_comb begin
    nextState = state;
    case (state)
      IDLE:         if (select != 4'b0000) nextState = ADD_ONES;
      ADD_ONES:     nextState = ADD_TENS;
      ADD_TENS:     nextState = ADD_HUNDREDS;
      ADD_HUNDREDS: nextState = IDLE;
      default:      nextState = IDLE;
    endcase
    if (newGame) nextState = IDLE;
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  // Pending event counters: saturate at 3, simultaneous increment and consume cancel out
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 4; i++) pend[i] <= 2'd0;
    end else if (newGame) begin
      for (int i = 0; i < 4; i++) pend[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (events[i] && !select[i]) begin
          if (pend[i] != 2'd3) pend[i] <= pend[i] + 2'd1;
        end else if (!events[i] && select[i]) begin
          pend[i] <= pend[i] - 2'd1;
        end
      end
    end
  end

  // Accumulator datapath: latch addend in idle, then write back one digit per step;
  // once saturated the accumulator is frozen at 999 while events keep draining
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc            <= 12'h000;
      addend         <= 12'h000;
      carry          <= 1'b0;
      scoreSaturated <= 1'b0;
    end else if (newGame) begin
      acc            <= 12'h000;
      addend         <= 12'h000;
      carry          <= 1'b0;
      scoreSaturated <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (select != 4'b0000) begin
            addend <= selAddend;
            carry  <= 1'b0;
          end
        end
        ADD_ONES: begin
          if (!scoreSaturated) acc[3:0] <= sumDigit;
          carry <= sumCarry;
        end
        ADD_TENS: begin
          if (!scoreSaturated) acc[7:4] <= sumDigit;
          carry <= sumCarry;
        end
        ADD_HUNDREDS: begin
          if (!scoreSaturated) begin
            if (sumCarry) begin
              acc            <= 12'h999;
              scoreSaturated <= 1'b1;
            end else begin
              acc[11:8] <= sumDigit;
            end
          end
          carry <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Display digits refresh only at a frame start that finds the adder idle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      onesDigit     <= 4'h0;
      tensDigit     <= 4'h0;
      hundredsDigit <= 4'h0;
    end else if (newGame) begin
      onesDigit     <= 4'h0;
      tensDigit     <= 4'h0;
      hundredsDigit <= 4'h0;
    end else if (startOfFrame && state == IDLE) begin
      onesDigit     <= acc[3:0];
      tensDigit     <= acc[7:4];
      hundredsDigit <= acc[11:8];
    end
  end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed self-checking bench for score_bcd_counter.
module tb_score_bcd_counter;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       newGame;
  logic       pelletEaten;
  logic       powerEaten;
  logic       fruitEaten;
  logic       ghostEaten;
  logic [3:0] onesDigit;
  logic [3:0] tensDigit;
  logic [3:0] hundredsDigit;
  logic       busy;
  logic       scoreSaturated;

  int total;
  int bad;

  score_bcd_counter dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .newGame        (newGame),
    .pelletEaten    (pelletEaten),
    .powerEaten     (powerEaten),
    .fruitEaten     (fruitEaten),
    .ghostEaten     (ghostEaten),
    .onesDigit      (onesDigit),
    .tensDigit      (tensDigit),
    .hundredsDigit  (hundredsDigit),
    .busy           (busy),
    .scoreSaturated (scoreSaturated)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and land just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle event pulse; vector order is {ghost, fruit, power, pellet}
  task automatic pulse(input logic [3:0] ev);
    {ghostEaten, fruitEaten, powerEaten, pelletEaten} = ev;
    tick();
    {ghostEaten, fruitEaten, powerEaten, pelletEaten} = 4'b0000;
  endtask

  // One-cycle frame start pulse
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // One-cycle newGame pulse
  task automatic clearGame();
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
  endtask

  // Single event followed by enough cycles for its add to finish
  task automatic addAndSettle(input logic [3:0] ev);
    pulse(ev);
    repeat (6) tick();
  endtask

  // Count busy cycles and rising edges of busy, sampling now and after each of n ticks
  task automatic countBusy(input int n, output int cnt, output int bursts, output int firstIdx);
    logic prev;
    cnt      = 0;
    bursts   = 0;
    firstIdx = -1;
    prev     = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i != 0) tick();
      if (busy) begin
        cnt++;
        if (!prev) bursts++;
        if (firstIdx < 0) firstIdx = i;
      end
      prev = busy;
    end
  endtask

  task automatic test_reset();
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    newGame      = 1'b0;
    {ghostEaten, fruitEaten, powerEaten, pelletEaten} = 4'b0000;
    #12;
    resetN = 1'b1;
    tick();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_digits got=%h expected=000", {hundredsDigit, tensDigit, onesDigit});
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_busy got=%b expected=0", busy);
    end
    total++;
    if (scoreSaturated !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_sat got=%b expected=0", scoreSaturated);
    end
  endtask

  task automatic test_single_pellet();
    int cnt, bursts, firstIdx;
    pulse(4'b0001);
    countBusy(8, cnt, bursts, firstIdx);
    total++;
    if (cnt !== 3) begin
      bad++;
      $display("[TB] FAIL pellet_busy_cycles got=%0d expected=3", cnt);
    end
    total++;
    if (firstIdx !== 1) begin
      bad++;
      $display("[TB] FAIL pellet_busy_latency got=%0d expected=1", firstIdx);
    end
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h010) begin
      bad++;
      $display("[TB] FAIL pellet_digits got=%h expected=010", {hundredsDigit, tensDigit, onesDigit});
    end
  endtask

  task automatic test_same_cycle();
    int cnt, bursts, firstIdx;
    clearGame();
    pulse(4'b1001);
    countBusy(12, cnt, bursts, firstIdx);
    total++;
    if (cnt !== 6) begin
      bad++;
      $display("[TB] FAIL dual_busy_cycles got=%0d expected=6", cnt);
    end
    total++;
    if (bursts !== 2) begin
      bad++;
      $display("[TB] FAIL dual_busy_bursts got=%0d expected=2", bursts);
    end
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h210) begin
      bad++;
      $display("[TB] FAIL dual_digits got=%h expected=210", {hundredsDigit, tensDigit, onesDigit});
    end
  endtask

  task automatic test_saturation();
    clearGame();
    // 4 ghosts + fruit + power + 4 pellets = 800 + 100 + 50 + 40 = 990
    for (int i = 0; i < 4; i++) addAndSettle(4'b1000);
    addAndSettle(4'b0100);
    addAndSettle(4'b0010);
    for (int i = 0; i < 4; i++) addAndSettle(4'b0001);
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h990 || scoreSaturated !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sat_build got=%h sat=%b expected=990 sat=0",
               {hundredsDigit, tensDigit, onesDigit}, scoreSaturated);
    end
    addAndSettle(4'b0001);
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h999 || scoreSaturated !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_overflow got=%h sat=%b expected=999 sat=1",
               {hundredsDigit, tensDigit, onesDigit}, scoreSaturated);
    end
    addAndSettle(4'b1000);
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h999 || scoreSaturated !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_hold got=%h sat=%b expected=999 sat=1",
               {hundredsDigit, tensDigit, onesDigit}, scoreSaturated);
    end
  endtask

  task automatic test_pending_cap();
    clearGame();
    total++;
    if (scoreSaturated !== 1'b0 || {hundredsDigit, tensDigit, onesDigit} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL newgame_clear got=%h sat=%b expected=000 sat=0",
               {hundredsDigit, tensDigit, onesDigit}, scoreSaturated);
    end
    pelletEaten = 1'b1;
    repeat (5) tick();
    pelletEaten = 1'b0;
    repeat (25) tick();
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h040) begin
      bad++;
      $display("[TB] FAIL cap_digits got=%h expected=040", {hundredsDigit, tensDigit, onesDigit});
    end
  endtask

  task automatic test_newgame_mid_add();
    int cnt, bursts, firstIdx;
    pulse(4'b0001);
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midadd_busy got=%b expected=1", busy);
    end
    newGame    = 1'b1;
    fruitEaten = 1'b1;
    tick();
    newGame    = 1'b0;
    fruitEaten = 1'b0;
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h000 || busy !== 1'b0 || scoreSaturated !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midadd_clear got=%h busy=%b sat=%b expected=000 busy=0 sat=0",
               {hundredsDigit, tensDigit, onesDigit}, busy, scoreSaturated);
    end
    countBusy(8, cnt, bursts, firstIdx);
    total++;
    if (cnt !== 0) begin
      bad++;
      $display("[TB] FAIL midadd_fruit_dropped got=%0d expected=0 busy cycles", cnt);
    end
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL midadd_digits got=%h expected=000", {hundredsDigit, tensDigit, onesDigit});
    end
  endtask

  task automatic test_frame_hold();
    // Accumulator becomes 010 while the display still shows 000
    addAndSettle(4'b0001);
    pulse(4'b1000);
    tick();
    tick();
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL hold_while_busy got=%h expected=000", {hundredsDigit, tensDigit, onesDigit});
    end
    repeat (4) tick();
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h210) begin
      bad++;
      $display("[TB] FAIL hold_then_update got=%h expected=210", {hundredsDigit, tensDigit, onesDigit});
    end
  endtask

  task automatic test_reset_mid_add();
    pulse(4'b0100);
    tick();
    resetN = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || {hundredsDigit, tensDigit, onesDigit} !== 12'h000 || scoreSaturated !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_add got=%h busy=%b sat=%b expected=000 busy=0 sat=0",
               {hundredsDigit, tensDigit, onesDigit}, busy, scoreSaturated);
    end
    resetN = 1'b1;
    tick();
    frame();
    total++;
    if ({hundredsDigit, tensDigit, onesDigit} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_acc_cleared got=%h expected=000", {hundredsDigit, tensDigit, onesDigit});
    end
  endtask

  // Scenario sequence followed by the summary line
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_pellet();
    test_same_cycle();
    test_saturation();
    test_pending_cap();
    test_newgame_mid_add();
    test_frame_hold();
    test_reset_mid_add();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
